aes128_seq_ctrl: RTL
====================

AES128_SEQ_CTRL -- requirements
Module: aes128_seq_ctrl

Interface
REQ-001 SHALL have parameter KEY_LAT, default 2, giving the cycles the core needs after key change before round keys are valid (range 1..15).
REQ-002 SHALL have parameter CORE_LAT, default 12, giving the cycles from core input stable to core result valid (range 1..31).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): request handshake.
REQ-006 SHALL have ports in_mode (input, 1; 0=encrypt, 1=decrypt), in_key (input, 128) and in_data (input, 128): request payload.
REQ-007 SHALL have ports core_mode (output, 1), core_key (output, 128) and core_data (output, 128): registered drive to the AES-128 core.
REQ-008 SHALL have port core_result, input, 128: core output sampled by this block.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): response handshake.
REQ-010 SHALL have ports out_data (output, 128) and out_mode (output, 1): response payload.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, KEYEXP, RUN and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; a request is accepted when in_valid&in_ready is high at a rising edge (cycle T).
REQ-014 On acceptance, SHALL register in_mode, in_key and in_data onto core_mode, core_key and core_data, and hold them stable until the next acceptance.
REQ-015 On acceptance, SHALL enter KEYEXP with a down-counter loaded to KEY_LAT-1; on the counter reaching 0, SHALL move to RUN with the counter loaded to CORE_LAT-1.
REQ-016 In RUN, on the counter reaching 0, SHALL capture core_result into out_data and core_mode into out_mode, then enter DONE.
REQ-017 In DONE, SHALL hold out_valid=1 with out_data and out_mode stable until out_ready=1; on that handshake it SHALL return to IDLE.
REQ-018 Latency: out_valid SHALL first rise at T+1+KEY_LAT+CORE_LAT; with defaults this is T+15.
REQ-019 in_valid and in_ready SHALL never be high together outside IDLE; the block SHALL ignore in_valid in other states.
REQ-020 When out_ready is already high on entry to DONE, the block SHALL complete the response in one cycle, with in_ready=1 in the following cycle.
REQ-021 SHALL size the counter to ceil(log2(max(KEY_LAT,CORE_LAT)+1)) bits; it SHALL never wrap below 0.

Reset
REQ-022 On reset low, asynchronously: state=IDLE, counter=0, out_valid=0, in_ready=0, busy=0, and out_data, out_mode, core_key, core_data and core_mode all zero.
REQ-023 in_ready SHALL rise in the first cycle after reset deasserts.
REQ-024 Reset mid-operation (KEYEXP, RUN or DONE) SHALL abort the job with no response issued, and SHALL clear the key-cache valid flag.

Configuration
REQ-025 With macro AES128_SEQ_KEYCACHE_EN defined, SHALL keep a cache-valid flag plus the last accepted key; on acceptance with cache valid and in_key equal to the cached key, SHALL skip KEYEXP and enter RUN directly (latency T+1+CORE_LAT).
REQ-026 With AES128_SEQ_KEYCACHE_EN undefined, SHALL always traverse KEYEXP and SHALL instantiate no cache storage.

Structure
REQ-027 Shared package aes128_pkg SHALL hold: the FSM state typedef, the constant AES_BLK_W=128, and the mode encodings AES_ENC=0 and AES_DEC=1.
REQ-028 The latency down-counter SHALL be one sub-module, aes128_lat_cnt, with load, value and zero-flag ports.

Verification
REQ-029 Key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, mode 0, defaults -> out_valid at T+15 with out_data=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-030 Same key, data 69c4e0d86a7b0430d8cdb78070b4c55a, mode 1 -> out_data=00112233445566778899aabbccddeeff with out_mode=1; with the cache enabled, out_valid at T+13.
REQ-031 Hold out_ready=0 for 20 cycles in DONE -> out_valid and out_data stable, in_ready=0 throughout, and in_valid pulses ignored.
REQ-032 Pulse reset low during RUN (cycle T+8) -> all outputs zero immediately, no out_valid, in_ready=1 one cycle after release, and the next same-key job takes the full T+15.
REQ-033 Back-to-back jobs with out_ready tied high and in_valid tied high -> one acceptance every 2+KEY_LAT+CORE_LAT cycles with no dropped or duplicated responses.

Source files
------------

// File: rtl/aes128_pkg.sv
// Purpose: shared types and constants for the AES-128 sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state type, block width, mode encodings and a counter-width helper.
package aes128_pkg;

    localparam int   AES_BLK_W = 128;
    localparam logic AES_ENC   = 1'b0;
    localparam logic AES_DEC   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } aes_state_t;

    // Bits needed to hold the larger of the two latencies without wrapping.
    function automatic int lat_cnt_w(input int key_lat, input int core_lat);
        return $clog2(((key_lat > core_lat) ? key_lat : core_lat) + 1);
    endfunction

endpackage

// File: rtl/aes128_lat_cnt.sv
// Purpose: loadable latency down-counter with zero flag; saturates at zero.
// Latency: load/decrement visible one cycle after the edge that applies it.
// Backpressure: none; i_dec is ignored once the value has reached zero.
// Ports: clk, reset (async active-low), i_load/i_load_val (load), i_dec (count
//        enable), o_value (current count), o_zero (count is zero).
module aes128_lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_value,
    output logic         o_zero
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_dec && (r_value != '0)) begin
            r_value <= r_value - 1'b1;
        end
    end

    assign o_value = r_value;
    assign o_zero  = (r_value == '0);

endmodule

// File: rtl/aes128_seq_ctrl.sv
// Purpose: sequences one request at a time through an external AES-128 core.
// Latency: out_valid rises 1+KEY_LAT+CORE_LAT cycles after acceptance (1+CORE_LAT on key-cache hit).
// Backpressure: one job in flight; in_ready low until the response is taken via out_ready.
// Ports: clk, reset (async active-low); in_valid/in_ready + in_mode/in_key/in_data (request);
//        core_mode/core_key/core_data (registered drive to core), core_result (core output);
//        out_valid/out_ready + out_data/out_mode (response); busy (not IDLE).
// Optional feature: define AES128_SEQ_KEYCACHE_EN to skip key expansion when the key repeats.
module aes128_seq_ctrl
    import aes128_pkg::*;
#(
    parameter int KEY_LAT  = 2,
    parameter int CORE_LAT = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [AES_BLK_W-1:0] in_key,
    input  logic [AES_BLK_W-1:0] in_data,
    output logic                 core_mode,
    output logic [AES_BLK_W-1:0] core_key,
    output logic [AES_BLK_W-1:0] core_data,
    input  logic [AES_BLK_W-1:0] core_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 out_mode,
    output logic                 busy
);

    localparam int             CNT_W     = lat_cnt_w(KEY_LAT, CORE_LAT);
    localparam logic [CNT_W-1:0] KEY_LOAD  = CNT_W'(KEY_LAT - 1);
    localparam logic [CNT_W-1:0] CORE_LOAD = CNT_W'(CORE_LAT - 1);

    aes_state_t             r_state;
    aes_state_t             w_next_state;
    logic                   r_in_ready;
    logic                   r_core_mode;
    logic [AES_BLK_W-1:0]   r_core_key;
    logic [AES_BLK_W-1:0]   r_core_data;
    logic [AES_BLK_W-1:0]   r_out_data;
    logic                   r_out_mode;

    logic                   w_accept;
    logic                   w_cache_hit;
    logic                   w_cnt_load;
    logic [CNT_W-1:0]       w_cnt_load_val;
    logic                   w_cnt_dec;
    logic [CNT_W-1:0]       w_cnt_val;
    logic                   w_cnt_zero;

    // r_in_ready is only ever set while the FSM sits in IDLE.
    assign w_accept = in_valid & r_in_ready;

`ifdef AES128_SEQ_KEYCACHE_EN
    logic                 r_cache_vld;
    logic [AES_BLK_W-1:0] r_cache_key;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cache_vld <= 1'b0;
            r_cache_key <= '0;
        end else if (w_accept) begin
            r_cache_vld <= 1'b1;
            r_cache_key <= in_key;
        end
    end

    assign w_cache_hit = r_cache_vld && (in_key == r_cache_key);
`else
    assign w_cache_hit = 1'b0;
`endif

    aes128_lat_cnt #(
        .W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_value    (w_cnt_val),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_next_state   = r_state;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_dec      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cnt_load = 1'b1;
                    if (w_cache_hit) begin
                        w_next_state   = ST_RUN;
                        w_cnt_load_val = CORE_LOAD;
                    end else begin
                        w_next_state   = ST_KEYEXP;
                        w_cnt_load_val = KEY_LOAD;
                    end
                end
            end
            ST_KEYEXP: begin
                if (w_cnt_zero) begin
                    w_next_state   = ST_RUN;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = CORE_LOAD;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered so it stays low during reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state == ST_IDLE);
        end
    end

    // Core drive is held from one acceptance to the next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_core_mode <= AES_ENC;
            r_core_key  <= '0;
            r_core_data <= '0;
        end else if (w_accept) begin
            r_core_mode <= in_mode;
            r_core_key  <= in_key;
            r_core_data <= in_data;
        end
    end

    // Response is captured on the last RUN cycle and held through DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_data <= '0;
            r_out_mode <= AES_ENC;
        end else if ((r_state == ST_RUN) && w_cnt_zero) begin
            r_out_data <= core_result;
            r_out_mode <= r_core_mode;
        end
    end

    assign in_ready  = r_in_ready;
    assign core_mode = r_core_mode;
    assign core_key  = r_core_key;
    assign core_data = r_core_data;
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_out_data;
    assign out_mode  = r_out_mode;
    assign busy      = (r_state != ST_IDLE);

    // The counter must never exceed the load value of the phase it is timing.
    a_keyexp_bound: assert property (@(posedge clk) disable iff (!reset)
        (r_state == ST_KEYEXP) |-> (w_cnt_val <= KEY_LOAD));
    a_run_bound: assert property (@(posedge clk) disable iff (!reset)
        (r_state == ST_RUN) |-> (w_cnt_val <= CORE_LOAD));

endmodule
